// File: rtl/hamming_pkg.sv
// Hamming(7,4) shared constants and parity helper.
// Used by the encoder and by the matching decoder.
package hamming_pkg;

  localparam int DATA_W = 4;
  localparam int CW_W   = 7;

  localparam int P2_IDX = 2;
  localparam int P1_IDX = 1;
  localparam int P0_IDX = 0;

  function automatic logic [2:0] hamming_parity(
    input logic [DATA_W-1:0] d
  );
    logic [2:0] p;
    p[P2_IDX] = d[3] ^ d[0] ^ d[1];
    p[P1_IDX] = d[3] ^ d[0] ^ d[2];
    p[P0_IDX] = d[1] ^ d[2] ^ d[3];
    return p;
  endfunction

endpackage

// File: rtl/hamming_fifo.sv
// Synchronous codeword FIFO, DEPTH entries (power of 2).
// Head entry is visible on rdata_o without a read cycle.
module hamming_fifo
  import hamming_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CW_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointer/level; pointers wrap naturally at DEPTH.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and level state; reset discards buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/hamming_enc.sv
// Streaming Hamming(7,4) encoder with error injection.
// Codewords are buffered in a FIFO toward the link side.
module hamming_enc
  import hamming_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       din,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic                    inj_en,
  input  logic [CW_W-1:0]         inj_mask,
  output logic [CW_W-1:0]         cw,
  output logic                    cw_valid,
  input  logic                    cw_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        words
);

  logic [CW_W-1:0]  enc_w;
  logic [CW_W-1:0]  push_w;
  logic [CW_W-1:0]  head_w;
  logic             full_w;
  logic             empty_w;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] words_q, words_d;

  assign enc_w  = {din, hamming_parity(din)};
  assign push_w = enc_w ^ (inj_en ? inj_mask : '0);

  assign din_ready = !full_w;
  assign push      = din_valid && din_ready;
  assign cw_valid  = !empty_w;
  assign pop       = cw_valid && cw_ready;
  assign cw        = cw_valid ? head_w : '0;
  assign words     = words_q;

  hamming_fifo #(
    .DEPTH (DEPTH),
    .W     (CW_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_w),
    .rdata_o (head_w),
    .full_o  (full_w),
    .empty_o (empty_w),
    .level_o (level)
  );

  // Accepted-word count, wraps modulo 2^CNT_W.
  always_comb begin
    words_d = words_q;
    if (push) words_d = words_q + 1'b1;
  end

  // Counter state; an accept during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) words_q <= '0;
    else     words_q <= words_d;
  end

endmodule

// File: tb/tb_hamming_enc.sv
// Directed self-checking bench for hamming_enc.
// Checks encoding, FIFO order, backpressure, injection, reset.
module tb_hamming_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        inj_en;
  logic [6:0]  inj_mask;
  logic [6:0]  cw;
  logic        cw_valid;
  logic        cw_ready;
  logic [2:0]  level;
  logic [15:0] words;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_enc #(.DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .inj_en    (inj_en),
    .inj_mask  (inj_mask),
    .cw        (cw),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .level     (level),
    .words     (words)
  );

  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d, d[3]^d[0]^d[1], d[3]^d[0]^d[2], d[1]^d[2]^d[3]};
  endfunction

  function automatic logic [2:0] synd(input logic [6:0] c);
    return {c[6]^c[2]^c[3]^c[4],
            c[6]^c[1]^c[3]^c[5],
            c[0]^c[4]^c[5]^c[6]};
  endfunction

  function automatic logic [6:0] correct(input logic [6:0] c);
    logic [6:0] f;
    case (synd(c))
      3'b111:  f = 7'b1000000;
      3'b011:  f = 7'b0100000;
      3'b101:  f = 7'b0010000;
      3'b110:  f = 7'b0001000;
      3'b100:  f = 7'b0000100;
      3'b010:  f = 7'b0000010;
      3'b001:  f = 7'b0000001;
      default: f = 7'b0000000;
    endcase
    return c ^ f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic single(input logic [3:0] d, input logic [6:0] exp);
    din = d; din_valid = 1'b1; cw_ready = 1'b1;
    step();
    din_valid = 1'b0;
    chk("single_cw", 32'(cw), 32'(exp));
    chk("single_valid", 32'(cw_valid), 32'd1);
    step();
    chk("single_drain", 32'(cw_valid), 32'd0);
  endtask

  logic [6:0] q[$];
  logic [6:0] c;

  initial begin
    rst = 1'b1; din = 4'h5; din_valid = 1'b1;
    inj_en = 1'b0; inj_mask = '0; cw_ready = 1'b0;

    // 1: reset with din_valid held high
    do_reset(3);
    din_valid = 1'b0;
    chk("rst_cw_valid", 32'(cw_valid), 32'd0);
    chk("rst_cw", 32'(cw), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_words", 32'(words), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd1);

    // 2: single words, no bypass latency N+1
    single(4'b1011, 7'b1011100);
    single(4'h0, 7'h00);
    single(4'hF, 7'h7F);
    chk("words3", 32'(words), 32'd3);

    // 3: all 16 values through the decoder model
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      din = 4'(i); din_valid = 1'b1; cw_ready = 1'b1;
      step();
      din_valid = 1'b0;
      c = cw;
      chk("all_synd", 32'(synd(c)), 32'd0);
      chk("all_data", 32'(correct(c) >> 3), 32'(i));
      step();
    end
    chk("all_words", 32'(words), 32'd16);

    // 4: backpressure to full
    do_reset(1);
    cw_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      din = 4'(i); din_valid = 1'b1;
      step();
    end
    din = 4'd5;
    chk("bp_level4", 32'(level), 32'd4);
    chk("bp_ready0", 32'(din_ready), 32'd0);
    step();
    chk("bp_held_level", 32'(level), 32'd4);
    chk("bp_held_words", 32'(words), 32'd4);
    chk("bp_head1", 32'(cw), 32'(enc(4'd1)));
    cw_ready = 1'b1;
    step();
    chk("bp_head2", 32'(cw), 32'(enc(4'd2)));
    chk("bp_level3", 32'(level), 32'd3);
    chk("bp_ready1", 32'(din_ready), 32'd1);
    chk("bp_words4", 32'(words), 32'd4);
    step();
    din_valid = 1'b0;
    chk("bp_head3", 32'(cw), 32'(enc(4'd3)));
    chk("bp_level3b", 32'(level), 32'd3);
    chk("bp_words5", 32'(words), 32'd5);
    step();
    chk("bp_head4", 32'(cw), 32'(enc(4'd4)));
    step();
    chk("bp_head5", 32'(cw), 32'(enc(4'd5)));
    step();
    chk("bp_empty", 32'(level), 32'd0);

    // 5: steady state at level 2
    cw_ready = 1'b0; din_valid = 1'b1;
    din = 4'hA; q.push_back(enc(4'hA)); step();
    din = 4'hB; q.push_back(enc(4'hB)); step();
    cw_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = 4'(i + 3);
      chk("ss_head", 32'(cw), 32'(q.pop_front()));
      q.push_back(enc(4'(i + 3)));
      step();
      chk("ss_level", 32'(level), 32'd2);
    end
    din_valid = 1'b0;
    while (q.size() > 0) begin
      chk("ss_drain", 32'(cw), 32'(q.pop_front()));
      step();
    end
    chk("ss_empty", 32'(cw_valid), 32'd0);

    // 6: error injection and correction
    din = 4'b0001; din_valid = 1'b1; cw_ready = 1'b0;
    inj_en = 1'b1; inj_mask = 7'b0000100;
    step();
    din_valid = 1'b0;
    din = 4'b0010;
    step();
    chk("inj_cw", 32'(cw), 32'b0001010);
    chk("inj_idle_ignored", 32'(level), 32'd1);
    chk("inj_synd", 32'(synd(cw)), 32'b100);
    chk("inj_fix", 32'(correct(cw)), 32'b0001110);
    inj_en = 1'b0; inj_mask = '0;

    // mid-burst reset drops buffer and coincident accept
    din_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = 4'(i + 6);
      step();
    end
    din = 4'hC;
    do_reset(1);
    din_valid = 1'b0;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_valid", 32'(cw_valid), 32'd0);
    chk("mid_rst_words", 32'(words), 32'd0);
    din = 4'h9; din_valid = 1'b1; cw_ready = 1'b1;
    step();
    din_valid = 1'b0;
    chk("mid_rst_first", 32'(cw), 32'(enc(4'h9)));
    chk("mid_rst_words1", 32'(words), 32'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
